// File: rtl/gcn_coo_aggregate_argmax.sv
// rtl/gcn_coo_aggregate_argmax.sv - GCN neighbour aggregation over a COO edge list with per-node argmax
module gcn_coo_aggregate_argmax #(
  parameter int NUM_NODES      = 6,
  parameter int NUM_CLASSES    = 3,
  parameter int MAX_EDGES      = 6,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ACC_WIDTH      = DOT_PROD_WIDTH + 4,
  parameter int SELF_LOOP      = 1,
  localparam int NODE_BW  = $clog2(NUM_NODES),
  localparam int EDGE_BW  = $clog2(MAX_EDGES + 1),
  localparam int CLASS_BW = $clog2(NUM_CLASSES)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [EDGE_BW-1:0]                    num_edges,
  output logic [EDGE_BW-1:0]                    coo_address,
  input  logic [2*NODE_BW-1:0]                  coo_in,
  output logic [NODE_BW-1:0]                    fmw_address,
  input  logic [NUM_CLASSES*DOT_PROD_WIDTH-1:0] fmw_data,
  output logic                                  done,
  output logic                                  edge_err,
  output logic [NUM_NODES*CLASS_BW-1:0]         max_addi_answer
);

  localparam int KW = $clog2(NUM_NODES + 1);
  localparam logic [KW-1:0]      NODES_K   = KW'(NUM_NODES);
  localparam logic [KW-1:0]      LAST_K    = KW'(NUM_NODES - 1);
  localparam logic [NODE_BW:0]   NODES_W   = (NODE_BW + 1)'(NUM_NODES);
  localparam logic [EDGE_BW-1:0] MAX_E     = EDGE_BW'(MAX_EDGES);

  typedef enum logic [2:0] {IDLE, INIT, E_COO, E_SRC, E_DST, E_ACC, ARGMAX, DONE} state_t;

  state_t                state, state_nx;
  logic [KW-1:0]         k_q;
  logic [EDGE_BW-1:0]    e_q, cnt_q, e_next;
  logic [NODE_BW-1:0]    src_q, dst_q;
  logic [ACC_WIDTH-1:0]  agg [NUM_NODES][NUM_CLASSES];
  logic                  init_done, edge_bad;
  logic [CLASS_BW-1:0]   best_idx;
  logic [ACC_WIDTH-1:0]  best_val;
  logic [ACC_WIDTH-1:0]  row [NUM_CLASSES];

  function automatic logic [DOT_PROD_WIDTH-1:0] h_elem(input int c);
    return fmw_data[(NUM_CLASSES-1-c)*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
  endfunction

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [DOT_PROD_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH + 1)'(b);
    return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
  endfunction

  assign e_next    = e_q + EDGE_BW'(1);
  assign init_done = (SELF_LOOP != 0) ? (k_q == NODES_K) : 1'b1;
  assign edge_bad  = ({1'b0, src_q} >= NODES_W) || ({1'b0, dst_q} >= NODES_W);
  assign done      = (state == DONE);

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      row[c] = '0;
      for (int n = 0; n < NUM_NODES; n++)
        if (k_q == KW'(n)) row[c] = agg[n][c];
    end
    // Strict > keeps the lowest class index on ties.
    best_idx = '0;
    best_val = row[0];
    for (int c = 1; c < NUM_CLASSES; c++)
      if (row[c] > best_val) begin
        best_val = row[c];
        best_idx = CLASS_BW'(c);
      end
  end

  always_comb begin
    state_nx    = state;
    coo_address = '0;
    fmw_address = '0;
    case (state)
      IDLE:   if (start) state_nx = INIT;
      INIT: begin
        if (SELF_LOOP != 0 && k_q < NODES_K) fmw_address = k_q[NODE_BW-1:0];
        if (init_done) state_nx = (cnt_q == '0) ? ARGMAX : E_COO;
      end
      E_COO:  state_nx = E_SRC;
      E_SRC: begin
        fmw_address = coo_in[2*NODE_BW-1:NODE_BW];
        state_nx    = E_DST;
      end
      E_DST: begin
        fmw_address = dst_q;
        state_nx    = E_ACC;
      end
      E_ACC: begin
        coo_address = e_next;
        state_nx    = (e_next == cnt_q) ? ARGMAX : E_SRC;
      end
      ARGMAX: if (k_q == LAST_K) state_nx = DONE;
      DONE:   if (start) state_nx = INIT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      k_q             <= '0;
      e_q             <= '0;
      cnt_q           <= '0;
      src_q           <= '0;
      dst_q           <= '0;
      edge_err        <= 1'b0;
      max_addi_answer <= '0;
      for (int n = 0; n < NUM_NODES; n++)
        for (int c = 0; c < NUM_CLASSES; c++)
          agg[n][c] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, DONE: if (start) begin
          cnt_q    <= (num_edges > MAX_E) ? MAX_E : num_edges;
          edge_err <= 1'b0;
          k_q      <= '0;
        end
        INIT: begin
          k_q <= k_q + KW'(1);
          // Row k-1 arrives one cycle after its address was driven.
          for (int n = 0; n < NUM_NODES; n++)
            for (int c = 0; c < NUM_CLASSES; c++)
              if (SELF_LOOP == 0) agg[n][c] <= '0;
              else if (k_q == KW'(n + 1)) agg[n][c] <= ACC_WIDTH'(h_elem(c));
          if (init_done) begin
            k_q <= '0;
            e_q <= '0;
          end
        end
        E_SRC: begin
          src_q <= coo_in[2*NODE_BW-1:NODE_BW];
          dst_q <= coo_in[NODE_BW-1:0];
        end
        E_DST: begin
          if (edge_bad) edge_err <= 1'b1;
          else
            for (int n = 0; n < NUM_NODES; n++)
              if (dst_q == NODE_BW'(n))
                for (int c = 0; c < NUM_CLASSES; c++)
                  agg[n][c] <= sat_add(agg[n][c], h_elem(c));
        end
        E_ACC: begin
          e_q <= e_next;
          // Self edges contribute once; the mirror add is skipped.
          if (!edge_bad && src_q != dst_q)
            for (int n = 0; n < NUM_NODES; n++)
              if (src_q == NODE_BW'(n))
                for (int c = 0; c < NUM_CLASSES; c++)
                  agg[n][c] <= sat_add(agg[n][c], h_elem(c));
        end
        ARGMAX: begin
          k_q <= k_q + KW'(1);
          for (int n = 0; n < NUM_NODES; n++)
            if (k_q == KW'(n))
              max_addi_answer[(NUM_NODES-1-n)*CLASS_BW +: CLASS_BW] <= best_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_coo_aggregate_argmax.sv
// tb/tb_gcn_coo_aggregate_argmax.sv - directed self-checking bench for gcn_coo_aggregate_argmax
module tb_gcn_coo_aggregate_argmax;
  localparam int N = 6;

  logic clk = 1'b0;
  logic reset;
  logic start_m, start_n, start_s;
  logic [2:0] ne_m, ne_n, ne_s;
  logic [2:0] coo_a_m, coo_a_n, coo_a_s, fmw_a_m, fmw_a_n, fmw_a_s;
  logic [5:0] coo_in_m, coo_in_n, coo_in_s;
  logic [47:0] fmw_m, fmw_n, fmw_s;
  logic done_m, done_n, done_s, err_m, err_n, err_s;
  logic [11:0] ans_m, ans_n, ans_s;

  logic [47:0] hmem [0:7];
  logic [5:0]  coo_mem [0:7];

  int n_tests = 0;
  int n_fail  = 0;
  logic        exp_valid = 1'b0;
  logic [11:0] exp_ans, m_ans;
  logic        exp_err, m_err;
  int          lat;

  always #5 clk = ~clk;

  gcn_coo_aggregate_argmax u_main (
    .clk(clk), .reset(reset), .start(start_m), .num_edges(ne_m), .coo_address(coo_a_m),
    .coo_in(coo_in_m), .fmw_address(fmw_a_m), .fmw_data(fmw_m), .done(done_m),
    .edge_err(err_m), .max_addi_answer(ans_m));

  gcn_coo_aggregate_argmax #(.SELF_LOOP(0)) u_nsl (
    .clk(clk), .reset(reset), .start(start_n), .num_edges(ne_n), .coo_address(coo_a_n),
    .coo_in(coo_in_n), .fmw_address(fmw_a_n), .fmw_data(fmw_n), .done(done_n),
    .edge_err(err_n), .max_addi_answer(ans_n));

  gcn_coo_aggregate_argmax #(.ACC_WIDTH(16)) u_sat (
    .clk(clk), .reset(reset), .start(start_s), .num_edges(ne_s), .coo_address(coo_a_s),
    .coo_in(coo_in_s), .fmw_address(fmw_a_s), .fmw_data(fmw_s), .done(done_s),
    .edge_err(err_s), .max_addi_answer(ans_s));

  // Synchronous-read memories: data valid the cycle after the address.
  always @(posedge clk) begin
    coo_in_m <= coo_mem[coo_a_m];  fmw_m <= hmem[fmw_a_m];
    coo_in_n <= coo_mem[coo_a_n];  fmw_n <= hmem[fmw_a_n];
    coo_in_s <= coo_mem[coo_a_s];  fmw_s <= hmem[fmw_a_s];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (exp_valid && done_m && !reset) begin
      check("cmp_ans", 32'(ans_m), 32'(exp_ans));
      check("cmp_err", 32'(err_m), 32'(exp_err));
    end

  function automatic longint hval(input int n, input int c);
    logic [47:0] r;
    r = hmem[n];
    return longint'(r[(2-c)*16 +: 16]);
  endfunction

  task automatic model(input int ne, input bit sl, input int accw,
                       output logic [11:0] ans, output logic err);
    longint agg [N][3];
    longint lim, t;
    int cnt, s, d, best;
    logic [5:0] ed;
    lim = (longint'(1) << accw) - 1;
    cnt = (ne > 6) ? 6 : ne;
    err = 1'b0;
    ans = '0;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < 3; c++) agg[n][c] = sl ? hval(n, c) : 0;
    for (int e = 0; e < cnt; e++) begin
      ed = coo_mem[e];
      s = int'(ed[5:3]);
      d = int'(ed[2:0]);
      if (s >= N || d >= N) err = 1'b1;
      else
        for (int c = 0; c < 3; c++) begin
          t = agg[d][c] + hval(s, c);
          agg[d][c] = (t > lim) ? lim : t;
          if (s != d) begin
            t = agg[s][c] + hval(d, c);
            agg[s][c] = (t > lim) ? lim : t;
          end
        end
    end
    for (int n = 0; n < N; n++) begin
      best = 0;
      for (int c = 1; c < 3; c++) if (agg[n][c] > agg[n][best]) best = c;
      ans[(N-1-n)*2 +: 2] = 2'(best);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin hmem[i] = '0; coo_mem[i] = '0; end
  endtask

  task automatic set_h(input int n, input int c0, input int c1, input int c2);
    hmem[n] = {16'(c0), 16'(c1), 16'(c2)};
  endtask

  task automatic set_e(input int i, input int s, input int d);
    coo_mem[i] = {3'(s), 3'(d)};
  endtask

  task automatic load_t1();
    clear_mem();
    set_h(0, 1, 5, 2);
    set_h(1, 0, 0, 7);
    set_e(0, 0, 1);
  endtask

  function automatic logic done_of(input int w);
    return (w == 0) ? done_m : (w == 1) ? done_n : done_s;
  endfunction

  task automatic go(input int w, input logic [2:0] ne, output int l);
    exp_valid = 1'b0;
    case (w)
      0: begin ne_m = ne; start_m = 1'b1; end
      1: begin ne_n = ne; start_n = 1'b1; end
      default: begin ne_s = ne; start_s = 1'b1; end
    endcase
    @(posedge clk); #1;
    start_m = 1'b0; start_n = 1'b0; start_s = 1'b0;
    l = 1;
    while (!done_of(w) && l < 200) begin @(posedge clk); #1; l++; end
    check("run_timeout", 32'(done_of(w)), 32'd1);
  endtask

  task automatic arm();
    exp_ans = m_ans;
    exp_err = m_err;
    exp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start_m = 1'b0; start_n = 1'b0; start_s = 1'b0;
    ne_m = '0; ne_n = '0; ne_s = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_done", 32'(done_m), 0);
    check("rst_ans", 32'(ans_m), 0);
    check("rst_err", 32'(err_m), 0);
    check("rst_coo_a", 32'(coo_a_m), 0);
    check("rst_fmw_a", 32'(fmw_a_m), 0);

    // Basic one-edge run
    load_t1();
    model(1, 1, 20, m_ans, m_err);
    check("model_t1", 32'(m_ans), 32'hA00);
    go(0, 3'd1, lat);
    check("t1_lat", 32'(lat), 18);
    check("t1_ans", 32'(ans_m), 32'hA00);
    check("t1_err", 32'(err_m), 0);
    arm();

    // No edges: self-loop only
    model(0, 1, 20, m_ans, m_err);
    check("model_t2", 32'(m_ans), 32'h600);
    go(0, 3'd0, lat);
    check("t2_lat", 32'(lat), 14);
    check("t2_ans", 32'(ans_m), 32'h600);
    arm();

    // No self-loop variant
    model(0, 0, 20, m_ans, m_err);
    go(1, 3'd0, lat);
    check("nsl0_ans", 32'(ans_n), 32'(m_ans));
    check("nsl0_lit", 32'(ans_n), 32'h000);
    model(1, 0, 20, m_ans, m_err);
    check("model_nsl1", 32'(m_ans), 32'h900);
    go(1, 3'd1, lat);
    check("nsl1_ans", 32'(ans_n), 32'h900);

    // Self edge contributes once
    clear_mem();
    set_h(2, 2, 0, 0);
    set_h(3, 0, 5, 0);
    set_e(0, 2, 2);
    set_e(1, 2, 3);
    model(2, 1, 20, m_ans, m_err);
    check("model_t3", 32'(m_ans), 32'h050);
    go(0, 3'd2, lat);
    check("t3_lat", 32'(lat), 21);
    check("t3_ans", 32'(ans_m), 32'h050);
    arm();

    // Saturation at 16-bit accumulators
    clear_mem();
    set_h(0, 16'hFFFF, 0, 0);
    set_h(1, 16'hFFF0, 0, 16'hFFF8);
    set_e(0, 0, 1);
    model(1, 1, 16, m_ans, m_err);
    check("model_t4", 32'(m_ans), 32'h000);
    go(2, 3'd1, lat);
    check("t4_ans", 32'(ans_s), 32'h000);
    check("t4_err", 32'(err_s), 0);

    // Out-of-range edge ignored, flagged
    load_t1();
    set_e(0, 7, 0);
    set_e(1, 0, 1);
    model(2, 1, 20, m_ans, m_err);
    check("model_t5", 32'(m_ans), 32'hA00);
    check("model_t5_err", 32'(m_err), 1);
    go(0, 3'd2, lat);
    check("t5_lat", 32'(lat), 21);
    check("t5_ans", 32'(ans_m), 32'hA00);
    check("t5_err", 32'(err_m), 1);
    arm();

    // Edge count clamped to MAX_EDGES; entry 6 must not be used
    load_t1();
    set_e(1, 3, 4); set_e(2, 3, 4); set_e(3, 4, 5); set_e(4, 5, 5); set_e(5, 3, 3);
    set_e(6, 0, 2);
    model(7, 1, 20, m_ans, m_err);
    check("model_clamp", 32'(m_ans), 32'hA00);
    go(0, 3'd7, lat);
    check("clamp_lat", 32'(lat), 33);
    check("clamp_ans", 32'(ans_m), 32'hA00);
    check("clamp_err", 32'(err_m), 0);
    arm();

    // Reset mid-run while in E_DST, then rerun
    load_t1();
    model(1, 1, 20, m_ans, m_err);
    exp_valid = 1'b0;
    ne_m = 3'd1;
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("t6_in_edst", 32'(fmw_a_m), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_done", 32'(done_m), 0);
    check("t6_ans", 32'(ans_m), 0);
    check("t6_err", 32'(err_m), 0);
    check("t6_fmw_a", 32'(fmw_a_m), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_idle", 32'(done_m), 0);
    go(0, 3'd1, lat);
    check("t6_lat", 32'(lat), 18);
    check("t6_rerun", 32'(ans_m), 32'hA00);
    arm();

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
